idu_decode_stage: RTL
=====================

# idu_decode_stage

Registered, handshaked RV32I instruction decode stage for the NPC IDU. It accepts raw instructions from the IFU over a valid/ready interface and decodes opcode, funct3 and funct7 in a single stage into an instruction number, an immediate format, and register indices. Results go to the EXU through a 2-entry skid buffer, so every input and output handshake signal is registered or isolated. It is the parametrised successor of the per-opcode funct3 decode muxes: it has full-width decoding, an RV32E mode, back-pressure, and saturating decode/illegal counters.

## Interface
- ISA_WIDTH, 32, instruction width (fixed at 32 for RV32; any other value is illegal)
- INST_NUM_WIDTH, `INST_NUM_WIDTH, width of the instruction-number code (codes `beq, `lw, `addi, `inv, … from config.v)
- RV32E, 0, when 1 any rs1/rs2/rd index ≥ 16 marks the instruction illegal
- CNT_WIDTH, 16, width of the statistic counters

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  IFU holds a valid instruction
- in_ready  out  1  stage can accept an instruction
- in_inst  in  ISA_WIDTH  raw instruction
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  EXU accepts the decoded instruction
- out_inst  out  ISA_WIDTH  raw instruction, passed through
- out_inst_num  out  INST_NUM_WIDTH  decoded instruction code, `inv if illegal
- out_imm_type  out  3  0 none, 1 I, 2 S, 3 B, 4 U, 5 J
- out_rd, out_rs1, out_rs2  out  5 each  register fields (rs2 is zeroed for I/U/J types)
- out_illegal  out  1  instruction not in the supported set
- clr_cnt  in  1  synchronous clear of both counters
- cnt_inst  out  CNT_WIDTH  decoded instructions delivered
- cnt_illegal  out  CNT_WIDTH  illegal instructions delivered

## Operation
- Supported set:
  - lui, auipc, jal, jalr
  - beq, bne, blt, bge, bltu, bgeu
  - lb, lh, lw, lbu, lhu
  - sb, sh, sw
  - addi, slti, sltiu, xori, ori, andi, slli, srli, srai
  - add, sub, sll, slt, sltu, xor, srl, sra, or, and
  - ecall, ebreak
- Every other encoding gives out_inst_num=`inv and out_illegal=1. This covers reserved funct3, funct7 other than 0000000/0100000 where relevant, slli/srli/srai with imm[11:5] invalid, and inst[1:0]≠11.
- An illegal instruction still flows downstream as a valid beat; the stage never drops or stalls on it.
- Decode is combinational on the accepted word. Results are stored already decoded in the skid entry and the output register.
- Storage: output register (OR) plus skid register (SK), each with its own valid bit.
- in_ready = !SK.valid.
- Accept = in_valid & in_ready.
- Each cycle, in priority order:
  1. If OR is empty or out_ready=1: OR loads from SK if SK is valid, else from the input if Accept, else OR becomes empty.
  2. SK captures the input when Accept occurs, OR stays occupied, and out_ready=0.
  3. SK is freed when it moves into OR.
- Order is strictly preserved. No beat is duplicated or lost.
- Counters update on a delivery, defined as out_valid & out_ready:
  - cnt_inst += 1 on every delivery.
  - cnt_illegal += 1 on a delivery with out_illegal=1.
  - Both saturate at all-ones.
  - clr_cnt=1 forces both counters to 0 that cycle, and this overrides a simultaneous delivery.

## Timing
- Reset (rst=0, asynchronous):
  - out_valid=0, SK.valid=0 (so in_ready=1), out_inst_num=`inv, out_illegal=0.
  - All other data outputs and both counters = 0.
  - A reset mid-transfer discards OR and SK contents.
- Latency: an instruction accepted at edge N is on the outputs after edge N with out_valid=1, i.e. 1 cycle.
- Throughput: 1 instruction per cycle while out_ready=1.
- in_ready depends only on registered state, with no combinational path from out_ready.
- Stall: when out_ready drops, one more beat can be accepted into SK, then in_ready=0 from the next cycle.
- On release, SK drains before new input is taken; in_ready returns to 1 the cycle after SK drains.
- Output data is stable while out_valid=1 and out_ready=0.

## Test plan
- Reset then stream addi x1,x0,5 (0x00500093), add x3,x1,x2 (0x002081B3), beq (0x00208463) with out_ready=1 -> out_inst_num = `addi, `add, `beq on consecutive cycles, out_imm_type 1/0/3, cnt_inst=3.
- Send 0x0000A003 (lw with funct3=010 is legal) and 0x00007003 (load funct3=111) -> first gives `lw; second gives `inv with out_illegal=1, cnt_illegal=1.
- Hold out_ready=0 while feeding 3 back-to-back instructions -> 2 accepted, in_ready=0 on the 3rd. Raise out_ready -> all 3 delivered in order, none lost.
- RV32E=1, add x17,x1,x2 (0x002088B3) -> `inv, out_illegal=1. The same instruction with RV32E=0 -> `add.
- CNT_WIDTH=4, deliver 20 instructions -> cnt_inst stays at 15. Then clr_cnt together with a delivery -> cnt_inst=0 the next cycle.
- Assert rst low while OR and SK are both full -> out_valid=0 and in_ready=1 immediately, counters 0; after release the next instruction decodes normally.

Source files
------------

// File: rtl/idu_decode_stage.sv
// idu_decode_stage: registered RV32I decode stage with a 2-entry skid buffer.
// Decodes opcode/funct3/funct7 of each accepted word into an instruction
// number, immediate format and register indices. The decoded result is held
// in an output register (OR) backed by a skid register (SK). Saturating
// counters track delivered and illegal instructions.
// The instruction-number codes are defined locally below; C_INV marks an
// illegal encoding. Only ISA_WIDTH = 32 is meaningful.
module idu_decode_stage #(
    parameter int ISA_WIDTH      = 32,
    parameter int INST_NUM_WIDTH = 6,
    parameter bit RV32E          = 1'b0,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ISA_WIDTH-1:0]      in_inst,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ISA_WIDTH-1:0]      out_inst,
    output logic [INST_NUM_WIDTH-1:0] out_inst_num,
    output logic [2:0]                out_imm_type,
    output logic [4:0]                out_rd,
    output logic [4:0]                out_rs1,
    output logic [4:0]                out_rs2,
    output logic                      out_illegal,
    input  logic                      clr_cnt,
    output logic [CNT_WIDTH-1:0]      cnt_inst,
    output logic [CNT_WIDTH-1:0]      cnt_illegal
);

    localparam logic [INST_NUM_WIDTH-1:0]
        C_INV   = INST_NUM_WIDTH'(0),  C_LUI   = INST_NUM_WIDTH'(1),
        C_AUIPC = INST_NUM_WIDTH'(2),  C_JAL   = INST_NUM_WIDTH'(3),
        C_JALR  = INST_NUM_WIDTH'(4),  C_BEQ   = INST_NUM_WIDTH'(5),
        C_BNE   = INST_NUM_WIDTH'(6),  C_BLT   = INST_NUM_WIDTH'(7),
        C_BGE   = INST_NUM_WIDTH'(8),  C_BLTU  = INST_NUM_WIDTH'(9),
        C_BGEU  = INST_NUM_WIDTH'(10), C_LB    = INST_NUM_WIDTH'(11),
        C_LH    = INST_NUM_WIDTH'(12), C_LW    = INST_NUM_WIDTH'(13),
        C_LBU   = INST_NUM_WIDTH'(14), C_LHU   = INST_NUM_WIDTH'(15),
        C_SB    = INST_NUM_WIDTH'(16), C_SH    = INST_NUM_WIDTH'(17),
        C_SW    = INST_NUM_WIDTH'(18), C_ADDI  = INST_NUM_WIDTH'(19),
        C_SLTI  = INST_NUM_WIDTH'(20), C_SLTIU = INST_NUM_WIDTH'(21),
        C_XORI  = INST_NUM_WIDTH'(22), C_ORI   = INST_NUM_WIDTH'(23),
        C_ANDI  = INST_NUM_WIDTH'(24), C_SLLI  = INST_NUM_WIDTH'(25),
        C_SRLI  = INST_NUM_WIDTH'(26), C_SRAI  = INST_NUM_WIDTH'(27),
        C_ADD   = INST_NUM_WIDTH'(28), C_SUB   = INST_NUM_WIDTH'(29),
        C_SLL   = INST_NUM_WIDTH'(30), C_SLT   = INST_NUM_WIDTH'(31),
        C_SLTU  = INST_NUM_WIDTH'(32), C_XOR   = INST_NUM_WIDTH'(33),
        C_SRL   = INST_NUM_WIDTH'(34), C_SRA   = INST_NUM_WIDTH'(35),
        C_OR    = INST_NUM_WIDTH'(36), C_AND   = INST_NUM_WIDTH'(37),
        C_ECALL = INST_NUM_WIDTH'(38), C_EBREAK = INST_NUM_WIDTH'(39);

    localparam logic [2:0] IMM_NONE = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2,
                           IMM_B = 3'd3, IMM_U = 3'd4, IMM_J = 3'd5;

    localparam int PKT_W = ISA_WIDTH + INST_NUM_WIDTH + 3 + 15 + 1;
    localparam logic [PKT_W-1:0] PKT_RST = {{ISA_WIDTH{1'b0}}, C_INV, IMM_NONE, 15'd0, 1'b0};

    logic [6:0]                w_op;
    logic [2:0]                w_f3;
    logic [6:0]                w_f7;
    logic [4:0]                w_rd_raw;
    logic [4:0]                w_rs1_raw;
    logic [4:0]                w_rs2_raw;
    logic [INST_NUM_WIDTH-1:0] w_num_raw;
    logic [2:0]                w_ty_raw;
    logic                      w_use_rd;
    logic                      w_use_rs1;
    logic                      w_use_rs2;
    logic                      w_bad_reg;
    logic                      w_ill;
    logic [INST_NUM_WIDTH-1:0] w_num;
    logic [2:0]                w_ty;
    logic [4:0]                w_rs2;
    logic [PKT_W-1:0]          w_dec_pkt;
    logic                      w_accept;
    logic                      w_or_free;
    logic                      w_deliver;

    logic                      r_or_valid;
    logic                      r_sk_valid;
    logic [PKT_W-1:0]          r_or_pkt;
    logic [PKT_W-1:0]          r_sk_pkt;
    logic [CNT_WIDTH-1:0]      r_cnt_inst;
    logic [CNT_WIDTH-1:0]      r_cnt_ill;

    assign w_op      = in_inst[6:0];
    assign w_f3      = in_inst[14:12];
    assign w_f7      = in_inst[31:25];
    assign w_rd_raw  = in_inst[11:7];
    assign w_rs1_raw = in_inst[19:15];
    assign w_rs2_raw = in_inst[24:20];

    // Map opcode/funct3/funct7 to an instruction code and immediate format.
    always_comb begin
        w_num_raw = C_INV;
        w_ty_raw  = IMM_NONE;
        if (w_op[1:0] == 2'b11) begin
            case (w_op[6:2])
                5'b01101: begin w_num_raw = C_LUI;   w_ty_raw = IMM_U; end
                5'b00101: begin w_num_raw = C_AUIPC; w_ty_raw = IMM_U; end
                5'b11011: begin w_num_raw = C_JAL;   w_ty_raw = IMM_J; end
                5'b11001: begin
                    w_ty_raw = IMM_I;
                    if (w_f3 == 3'b000) w_num_raw = C_JALR;
                end
                5'b11000: begin
                    w_ty_raw = IMM_B;
                    case (w_f3)
                        3'b000:  w_num_raw = C_BEQ;
                        3'b001:  w_num_raw = C_BNE;
                        3'b100:  w_num_raw = C_BLT;
                        3'b101:  w_num_raw = C_BGE;
                        3'b110:  w_num_raw = C_BLTU;
                        3'b111:  w_num_raw = C_BGEU;
                        default: w_num_raw = C_INV;
                    endcase
                end
                5'b00000: begin
                    w_ty_raw = IMM_I;
                    case (w_f3)
                        3'b000:  w_num_raw = C_LB;
                        3'b001:  w_num_raw = C_LH;
                        3'b010:  w_num_raw = C_LW;
                        3'b100:  w_num_raw = C_LBU;
                        3'b101:  w_num_raw = C_LHU;
                        default: w_num_raw = C_INV;
                    endcase
                end
                5'b01000: begin
                    w_ty_raw = IMM_S;
                    case (w_f3)
                        3'b000:  w_num_raw = C_SB;
                        3'b001:  w_num_raw = C_SH;
                        3'b010:  w_num_raw = C_SW;
                        default: w_num_raw = C_INV;
                    endcase
                end
                5'b00100: begin
                    w_ty_raw = IMM_I;
                    case (w_f3)
                        3'b000:  w_num_raw = C_ADDI;
                        3'b010:  w_num_raw = C_SLTI;
                        3'b011:  w_num_raw = C_SLTIU;
                        3'b100:  w_num_raw = C_XORI;
                        3'b110:  w_num_raw = C_ORI;
                        3'b111:  w_num_raw = C_ANDI;
                        3'b001:  w_num_raw = (w_f7 == 7'b0000000) ? C_SLLI : C_INV;
                        3'b101: begin
                            if (w_f7 == 7'b0000000)      w_num_raw = C_SRLI;
                            else if (w_f7 == 7'b0100000) w_num_raw = C_SRAI;
                        end
                        default: w_num_raw = C_INV;
                    endcase
                end
                5'b01100: begin
                    w_ty_raw = IMM_NONE;
                    if (w_f7 == 7'b0000000) begin
                        case (w_f3)
                            3'b000:  w_num_raw = C_ADD;
                            3'b001:  w_num_raw = C_SLL;
                            3'b010:  w_num_raw = C_SLT;
                            3'b011:  w_num_raw = C_SLTU;
                            3'b100:  w_num_raw = C_XOR;
                            3'b101:  w_num_raw = C_SRL;
                            3'b110:  w_num_raw = C_OR;
                            default: w_num_raw = C_AND;
                        endcase
                    end else if (w_f7 == 7'b0100000) begin
                        if (w_f3 == 3'b000)      w_num_raw = C_SUB;
                        else if (w_f3 == 3'b101) w_num_raw = C_SRA;
                    end
                end
                5'b11100: begin
                    w_ty_raw = IMM_I;
                    if (in_inst[31:7] == 25'h0000000)      w_num_raw = C_ECALL;
                    else if (in_inst[31:7] == 25'h0002000) w_num_raw = C_EBREAK;
                end
                default: w_num_raw = C_INV;
            endcase
        end
    end

    // Only the register fields an instruction actually uses are range-checked
    // in RV32E mode; U/J rs1 and I rs2 positions hold immediate bits.
    assign w_use_rd  = (w_ty_raw != IMM_S) && (w_ty_raw != IMM_B);
    assign w_use_rs1 = (w_ty_raw != IMM_U) && (w_ty_raw != IMM_J);
    assign w_use_rs2 = (w_ty_raw == IMM_NONE) || (w_ty_raw == IMM_S) || (w_ty_raw == IMM_B);
    assign w_bad_reg = RV32E && ((w_use_rd && w_rd_raw[4]) || (w_use_rs1 && w_rs1_raw[4]) ||
                                 (w_use_rs2 && w_rs2_raw[4]));

    assign w_ill     = (w_num_raw == C_INV) || w_bad_reg;
    assign w_num     = w_ill ? C_INV : w_num_raw;
    assign w_ty      = w_ill ? IMM_NONE : w_ty_raw;
    assign w_rs2     = ((w_ty == IMM_I) || (w_ty == IMM_U) || (w_ty == IMM_J)) ? 5'd0 : w_rs2_raw;
    assign w_dec_pkt = {in_inst, w_num, w_ty, w_rd_raw, w_rs1_raw, w_rs2, w_ill};

    assign in_ready  = !r_sk_valid;
    assign w_accept  = in_valid && !r_sk_valid;
    assign w_or_free = !r_or_valid || out_ready;
    assign w_deliver = r_or_valid && out_ready;

    // Skid buffer: OR refills from SK first so order is preserved; SK only
    // catches a beat when OR is held by back-pressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_or_valid <= 1'b0;
            r_sk_valid <= 1'b0;
            r_or_pkt   <= PKT_RST;
            r_sk_pkt   <= PKT_RST;
        end else if (w_or_free) begin
            if (r_sk_valid) begin
                r_or_pkt   <= r_sk_pkt;
                r_or_valid <= 1'b1;
                r_sk_valid <= 1'b0;
            end else if (w_accept) begin
                r_or_pkt   <= w_dec_pkt;
                r_or_valid <= 1'b1;
            end else begin
                r_or_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_sk_pkt   <= w_dec_pkt;
            r_sk_valid <= 1'b1;
        end
    end

    // Saturating delivery statistics; clear wins over a same-cycle delivery.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt_inst <= '0;
            r_cnt_ill  <= '0;
        end else if (clr_cnt) begin
            r_cnt_inst <= '0;
            r_cnt_ill  <= '0;
        end else if (w_deliver) begin
            if (r_cnt_inst != '1) r_cnt_inst <= r_cnt_inst + CNT_WIDTH'(1);
            if (out_illegal && (r_cnt_ill != '1)) r_cnt_ill <= r_cnt_ill + CNT_WIDTH'(1);
        end
    end

    assign out_valid = r_or_valid;
    assign {out_inst, out_inst_num, out_imm_type, out_rd, out_rs1, out_rs2, out_illegal} = r_or_pkt;
    assign cnt_inst    = r_cnt_inst;
    assign cnt_illegal = r_cnt_ill;

endmodule
